// File: rtl/if_id_skid_stage.sv
// IF/ID stage register with optional one-entry skid buffer, flush bubble and stall counter.
// Latency 1 cycle when empty; SKID_EN=1 gives a state-derived ready_o, SKID_EN=0 a combinational one.
module if_id_skid_stage #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = WORD_WIDTH'(32'h0000_0013),
    parameter bit                    SKID_EN    = 1'b1,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [WORD_WIDTH-1:0] program_count_i,
    input  logic [WORD_WIDTH-1:0] pc_plus4_i,
    input  logic [WORD_WIDTH-1:0] instruction_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [WORD_WIDTH-1:0] program_count_o,
    output logic [WORD_WIDTH-1:0] pc_plus4_o,
    output logic [WORD_WIDTH-1:0] instruction_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] pc4_q, pc4_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic [WORD_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [WORD_WIDTH-1:0] skid_pc4_q, skid_pc4_d;
    logic [WORD_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    logic out_ok;
    logic out_fire;
    logic in_fire;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        instr_d      = instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;
        stall_cnt_d  = stall_cnt_q;

        valid_o  = (state_q != ST_EMPTY);
        out_ok   = ready_i & ~stall_i;
        out_fire = valid_o & out_ok;
        if (SKID_EN) begin
            ready_o = rst_n & (state_q != ST_SKID);
        end else begin
            ready_o = rst_n & (~valid_o | out_ok);
        end
        in_fire = valid_i & ready_o;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_FULL;
                    pc_d    = program_count_i;
                    pc4_d   = pc_plus4_i;
                    instr_d = instruction_i;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    pc_d    = program_count_i;
                    pc4_d   = pc_plus4_i;
                    instr_d = instruction_i;
                end else if (in_fire) begin
                    // Only reachable with the skid buffer: ready_o is 0 here otherwise.
                    state_d      = ST_SKID;
                    skid_pc_d    = program_count_i;
                    skid_pc4_d   = pc_plus4_i;
                    skid_instr_d = instruction_i;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_d = ST_FULL;
                    pc_d    = skid_pc_q;
                    pc4_d   = skid_pc4_q;
                    instr_d = skid_instr_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (valid_o && !out_ok && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end

        // Flush leaves PC fields as they were; only the instruction becomes a bubble.
        if (flush_i) begin
            state_d = ST_EMPTY;
            pc_d    = pc_q;
            pc4_d   = pc4_q;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            pc_q         <= '0;
            pc4_q        <= '0;
            instr_q      <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            skid_instr_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            instr_q      <= instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign program_count_o = pc_q;
    assign pc_plus4_o      = pc4_q;
    assign instruction_o   = instr_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench: accepted entries are queued as expected outputs and a negedge monitor
// checks every delivered entry in order; inline checks cover handshake, flush, reset and counter.
module tb_if_id_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_i, stall_i, flush_i;
    logic [31:0] pc_i, pc4_i, instr_i;
    logic        ready_o, valid_o;
    logic [31:0] pc_o, pc4_o, instr_o;
    logic [15:0] stall_cnt;

    logic        c3_ready_o, c3_valid_o;
    logic [31:0] c3_pc_o, c3_pc4_o, c3_instr_o;
    logic [2:0]  c3_stall_cnt;

    logic        ns_valid_i, ns_ready_i, ns_stall_i, ns_flush_i;
    logic [31:0] ns_pc_i, ns_pc4_i, ns_instr_i;
    logic        ns_ready_o, ns_valid_o;
    logic [31:0] ns_pc_o, ns_pc4_o, ns_instr_o;
    logic [15:0] ns_stall_cnt;

    int     n_vec = 0;
    int     n_err = 0;
    entry_t sbq[$];

    always #5 clk = ~clk;

    if_id_skid_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .program_count_i(pc_i), .pc_plus4_i(pc4_i), .instruction_i(instr_i),
        .valid_o(valid_o), .ready_i(ready_i), .stall_i(stall_i), .flush_i(flush_i),
        .program_count_o(pc_o), .pc_plus4_o(pc4_o), .instruction_o(instr_o),
        .stall_cnt_o(stall_cnt)
    );

    if_id_skid_stage #(.CNT_WIDTH(3)) dut_c3 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(c3_ready_o),
        .program_count_i(pc_i), .pc_plus4_i(pc4_i), .instruction_i(instr_i),
        .valid_o(c3_valid_o), .ready_i(ready_i), .stall_i(stall_i), .flush_i(flush_i),
        .program_count_o(c3_pc_o), .pc_plus4_o(c3_pc4_o), .instruction_o(c3_instr_o),
        .stall_cnt_o(c3_stall_cnt)
    );

    if_id_skid_stage #(.SKID_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .valid_i(ns_valid_i), .ready_o(ns_ready_o),
        .program_count_i(ns_pc_i), .pc_plus4_i(ns_pc4_i), .instruction_i(ns_instr_i),
        .valid_o(ns_valid_o), .ready_i(ns_ready_i), .stall_i(ns_stall_i), .flush_i(ns_flush_i),
        .program_count_o(ns_pc_o), .pc_plus4_o(ns_pc4_o), .instruction_o(ns_instr_o),
        .stall_cnt_o(ns_stall_cnt)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] pc);
        pc_i    = pc;
        pc4_i   = pc + 32'd4;
        instr_i = instr_of(pc);
    endtask

    task automatic set_ns(input logic [31:0] pc);
        ns_pc_i    = pc;
        ns_pc4_i   = pc + 32'd4;
        ns_instr_i = instr_of(pc);
    endtask

    // Scoreboard monitor for the main instance: deliveries are compared before the
    // same edge's acceptance is queued, and flush/reset discard everything held.
    always @(negedge clk) begin
        entry_t e;
        if (rst_n && valid_o && ready_i && !stall_i) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got pc 0x%08h expected no output", pc_o);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", pc_o, e.pc);
                chk("sb_pc4", pc4_o, e.pc4);
                chk("sb_instr", instr_o, e.instr);
            end
        end
        if (!rst_n || flush_i) begin
            sbq.delete();
        end else if (valid_i && ready_o) begin
            sbq.push_back('{pc: pc_i, pc4: pc4_i, instr: instr_i});
        end
    end

    initial begin
        rst_n = 1'b0;
        valid_i = 1'b0; ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        set_in(32'h0);
        ns_valid_i = 1'b0; ns_ready_i = 1'b0; ns_stall_i = 1'b0; ns_flush_i = 1'b0;
        set_ns(32'h0);

        // Reset then stream
        tick(); tick();
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1; valid_i = 1'b1; ready_i = 1'b1; set_in(32'h0);
        #1 chk("empty_ready", 32'(ready_o), 32'd1);
        tick(); chk("lat_pc0", pc_o, 32'h0); chk("lat_valid", 32'(valid_o), 32'd1);
        set_in(32'h4);
        tick(); chk("stream_pc4", pc_o, 32'h4);
        set_in(32'h8);
        tick(); chk("stream_pc8", pc_o, 32'h8);
        valid_i = 1'b0;
        tick(); chk("stream_drain", 32'(valid_o), 32'd0);
        chk("stream_cnt", 32'(stall_cnt), 32'd0);

        // Skid fill and ordered drain
        ready_i = 1'b0; valid_i = 1'b1; set_in(32'h100);
        tick(); chk("skid_pc100", pc_o, 32'h100);
        set_in(32'h104);
        tick(); valid_i = 1'b0;
        chk("skid_ready", 32'(ready_o), 32'd0);
        chk("skid_valid", 32'(valid_o), 32'd1);
        chk("skid_hold_pc", pc_o, 32'h100);
        tick();
        chk("skid_stable_pc", pc_o, 32'h100);
        chk("skid_stable_instr", instr_o, instr_of(32'h100));
        ready_i = 1'b1;
        tick(); chk("skid_next_pc", pc_o, 32'h104); chk("skid_ready_back", 32'(ready_o), 32'd1);
        tick(); chk("skid_drained", 32'(valid_o), 32'd0);
        chk("skid_cnt", 32'(stall_cnt), 32'd2);

        // Flush from SKID with a simultaneous offer
        ready_i = 1'b0; valid_i = 1'b1; set_in(32'h200);
        tick(); set_in(32'h204);
        tick(); chk("fl_pre_ready", 32'(ready_o), 32'd0);
        set_in(32'h208); flush_i = 1'b1;
        tick(); flush_i = 1'b0; valid_i = 1'b0;
        chk("fl_valid", 32'(valid_o), 32'd0);
        chk("fl_instr", instr_o, NOP);
        chk("fl_pc_hold", pc_o, 32'h200);
        chk("fl_cnt_kept", 32'(stall_cnt), 32'd4);
        #1 chk("fl_ready", 32'(ready_o), 32'd1);
        valid_i = 1'b1; ready_i = 1'b1; set_in(32'h20C);
        tick(); chk("fl_next_pc", pc_o, 32'h20C); chk("fl_next_instr", instr_o, instr_of(32'h20C));
        valid_i = 1'b0;
        tick(); chk("fl_next_drain", 32'(valid_o), 32'd0);

        // Stall counter and saturation
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("st_cnt_clr", 32'(stall_cnt), 32'd0);
        stall_i = 1'b1; ready_i = 1'b1; valid_i = 1'b1; set_in(32'h300);
        tick(); valid_i = 1'b0;
        repeat (5) tick();
        chk("st_cnt5", 32'(stall_cnt), 32'd5);
        chk("st_c3_5", 32'(c3_stall_cnt), 32'd5);
        chk("st_hold_pc", pc_o, 32'h300);
        chk("st_valid", 32'(valid_o), 32'd1);
        repeat (5) tick();
        chk("st_cnt10", 32'(stall_cnt), 32'd10);
        chk("st_c3_sat", 32'(c3_stall_cnt), 32'd7);
        stall_i = 1'b0;
        tick(); chk("st_release", 32'(valid_o), 32'd0);

        // Single-register variant
        ns_ready_i = 1'b0; ns_valid_i = 1'b1; set_ns(32'h400);
        #1 chk("ns_ready_empty", 32'(ns_ready_o), 32'd1);
        tick(); chk("ns_pc400", ns_pc_o, 32'h400);
        chk("ns_ready_blocked", 32'(ns_ready_o), 32'd0);
        ns_ready_i = 1'b1; set_ns(32'h404);
        #1 chk("ns_ready_comb", 32'(ns_ready_o), 32'd1);
        tick(); chk("ns_pc404", ns_pc_o, 32'h404); chk("ns_valid", 32'(ns_valid_o), 32'd1);
        set_ns(32'h408);
        tick(); chk("ns_pc408", ns_pc_o, 32'h408); chk("ns_instr408", ns_instr_o, instr_of(32'h408));
        ns_valid_i = 1'b0;
        tick(); chk("ns_drain", 32'(ns_valid_o), 32'd0);

        // Reset while holding two entries
        ready_i = 1'b0; valid_i = 1'b1; set_in(32'h500);
        tick(); set_in(32'h504);
        tick(); valid_i = 1'b0;
        chk("mr_skid_ready", 32'(ready_o), 32'd0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mr_valid", 32'(valid_o), 32'd0);
        chk("mr_pc", pc_o, 32'h0);
        chk("mr_cnt", 32'(stall_cnt), 32'd0);
        chk("mr_instr", instr_o, NOP);
        ready_i = 1'b1;
        tick(); tick();
        chk("mr_no_emit", 32'(valid_o), 32'd0);
        valid_i = 1'b1; set_in(32'h600);
        tick(); chk("mr_next_pc", pc_o, 32'h600);
        valid_i = 1'b0;
        tick(); chk("mr_next_drain", 32'(valid_o), 32'd0);

        chk("sb_left", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
